// File: rtl/operand_stage.sv
// Operand-fetch stage ahead of the ALU: 8x16 register file with write-back bypass,
// immediate select, busy scoreboard and a registered valid/ready output stage.
module operand_stage #(
  parameter int WIDTH = 16,
  parameter int REGS  = 8,
  localparam int IW   = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alith,
  input  logic [IW-1:0]    in_rd,
  input  logic [IW-1:0]    in_rs1,
  input  logic [IW-1:0]    in_rs2,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alith,
  output logic [WIDTH-1:0] source1,
  output logic [WIDTH-1:0] source2,
  output logic [IW-1:0]    out_rd,
  input  logic             wb_en,
  input  logic [IW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data
);

  logic [WIDTH-1:0] rf [REGS];
  logic [REGS-1:0]  busy;
  logic [REGS-1:0]  wb_hit;
  logic [REGS-1:0]  busy_eff;
  logic [REGS-1:0]  busy_next;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             hazard;
  logic             accept;

  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_rd] = 1'b1;
  end

  // A register being written back this cycle no longer blocks a reader.
  assign busy_eff = busy & ~wb_hit;

  always_comb begin
    if (in_rs1 == '0)        rs1_val = '0;
    else if (wb_hit[in_rs1]) rs1_val = wb_data;
    else                     rs1_val = rf[in_rs1];

    if (in_rs2 == '0)        rs2_val = '0;
    else if (wb_hit[in_rs2]) rs2_val = wb_data;
    else                     rs2_val = rf[in_rs2];
  end

  assign hazard   = busy_eff[in_rs1] | (!in_use_imm & busy_eff[in_rs2]) | busy_eff[in_rd];
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first so a same-cycle re-issue to the same register keeps it busy.
  always_comb begin
    busy_next = busy_eff;
    if (accept && in_rd != '0) busy_next[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
      busy      <= '0;
      out_valid <= 1'b0;
      alith     <= '0;
      source1   <= '0;
      source2   <= '0;
      out_rd    <= '0;
    end else begin
      if (wb_en && wb_rd != '0) rf[wb_rd] <= wb_data;
      busy <= busy_next;
      if (accept) begin
        out_valid <= 1'b1;
        alith     <= in_alith;
        source1   <= rs1_val;
        source2   <= in_use_imm ? in_imm : rs2_val;
        out_rd    <= in_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alith;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alith;
  logic [15:0] source1;
  logic [15:0] source2;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alith(in_alith),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .alith(alith),
    .source1(source1), .source2(source2), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm);
    in_valid = 1'b1; in_alith = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm;
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] rd, input logic [15:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_alith = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 1'b0; in_imm = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    issue(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (alith !== 3'd0) begin n_fail++; $display("FAIL reset_alith got %0d want 0", alith); end
    n_checks++; if (source1 !== 16'h0) begin n_fail++; $display("FAIL reset_source1 got %h want 0000", source1); end
    n_checks++; if (source2 !== 16'h0) begin n_fail++; $display("FAIL reset_source2 got %h want 0000", source2); end
    n_checks++; if (out_rd !== 3'd0) begin n_fail++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_sub();
    idle();
    set_wb(1'b1, 3'd1, 16'd5); step();
    set_wb(1'b1, 3'd2, 16'd2); step();
    set_wb(1'b0, 3'd0, 16'd0);
    issue(3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'hDEAD);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sub_in_ready got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_out_valid got %0b want 1", out_valid); end
    n_checks++; if (alith !== 3'b001) begin n_fail++; $display("FAIL sub_alith got %b want 001", alith); end
    n_checks++; if (source1 !== 16'd5) begin n_fail++; $display("FAIL sub_source1 got %h want 0005", source1); end
    n_checks++; if (source2 !== 16'd2) begin n_fail++; $display("FAIL sub_source2 got %h want 0002", source2); end
    n_checks++; if (out_rd !== 3'd3) begin n_fail++; $display("FAIL sub_out_rd got %0d want 3", out_rd); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %0b want 0", out_valid); end
    n_checks++; if (source1 !== 16'd5) begin n_fail++; $display("FAIL drain_hold_source1 got %h want 0005", source1); end
  endtask

  task automatic test_imm_bypass();
    issue(3'b000, 3'd1, 3'd0, 3'd7, 1'b1, 16'h1234);
    step();
    n_checks++; if (source1 !== 16'h0) begin n_fail++; $display("FAIL imm_source1 got %h want 0000", source1); end
    n_checks++; if (source2 !== 16'h1234) begin n_fail++; $display("FAIL imm_source2 got %h want 1234", source2); end
    issue(3'b011, 3'd6, 3'd1, 3'd0, 1'b0, 16'h0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_a got %0b want 0", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_b got %0b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_accept got %0b want 0", out_valid); end
    set_wb(1'b1, 3'd1, 16'h1234);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_in_ready got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (source1 !== 16'h1234) begin n_fail++; $display("FAIL bypass_source1 got %h want 1234", source1); end
    n_checks++; if (out_rd !== 3'd6 || alith !== 3'b011) begin n_fail++; $display("FAIL bypass_rd_op got rd=%0d op=%b want rd=6 op=011", out_rd, alith); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(3'b110, 3'd2, 3'd2, 3'd1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || source1 !== 16'h1234 || source2 !== 16'h0 || alith !== 3'b011)
        begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0b s1=%h s2=%h op=%b want v=1 s1=1234 s2=0000 op=011", i, out_valid, source1, source2, alith); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (alith !== 3'b110) begin n_fail++; $display("FAIL passthru_alith got %b want 110", alith); end
    n_checks++; if (source1 !== 16'd2 || source2 !== 16'h1234 || out_rd !== 3'd2)
      begin n_fail++; $display("FAIL bp_next got s1=%h s2=%h rd=%0d want s1=0002 s2=1234 rd=2", source1, source2, out_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 16'h00AA);
    step();
    issue(3'b011, 3'd0, 3'd0, 3'd0, 1'b1, 16'h00BB);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %0b want 1", in_ready); end
    n_checks++; if (source2 !== 16'h00AA) begin n_fail++; $display("FAIL b2b_first got %h want 00aa", source2); end
    step();
    idle();
    n_checks++; if (out_valid !== 1'b1 || source2 !== 16'h00BB || alith !== 3'b011)
      begin n_fail++; $display("FAIL b2b_second got v=%0b s2=%h op=%b want v=1 s2=00bb op=011", out_valid, source2, alith); end
    step();
  endtask

  task automatic test_waw();
    issue(3'b000, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0001);
    step();
    issue(3'b001, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0002);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall got %0b want 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL waw_no_accept got %0b want 0", out_valid); end
    set_wb(1'b1, 3'd4, 16'd7);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 3'd4 || source2 !== 16'h0002)
      begin n_fail++; $display("FAIL waw_second got v=%0b rd=%0d s2=%h want v=1 rd=4 s2=0002", out_valid, out_rd, source2); end
    issue(3'b000, 3'd0, 3'd4, 3'd0, 1'b0, 16'h0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_set_wins got %0b want 0", in_ready); end
    step();
    set_wb(1'b1, 3'd4, 16'd9);
    step();
    idle();
    n_checks++; if (source1 !== 16'd9) begin n_fail++; $display("FAIL waw_read_r4 got %h want 0009", source1); end
    step();
  endtask

  task automatic test_r0();
    set_wb(1'b1, 3'd0, 16'hFFFF);
    step();
    issue(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h5A5A);
    step();
    idle();
    n_checks++; if (source1 !== 16'h0 || source2 !== 16'h0)
      begin n_fail++; $display("FAIL r0_read got s1=%h s2=%h want 0000 0000", source1, source2); end
    issue(3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    set_wb(1'b1, 3'd0, 16'hFFFF);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL r0_not_busy got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (source1 !== 16'h0) begin n_fail++; $display("FAIL r0_no_bypass got %h want 0000", source1); end
    step();
  endtask

  task automatic test_reset_mid();
    set_wb(1'b1, 3'd5, 16'hABCD);
    step();
    set_wb(1'b0, 3'd0, 16'h0);
    issue(3'b010, 3'd5, 3'd5, 3'd0, 1'b0, 16'h0);
    step();
    out_ready = 1'b0;
    idle();
    n_checks++; if (out_valid !== 1'b1 || source1 !== 16'hABCD)
      begin n_fail++; $display("FAIL pre_rst got v=%0b s1=%h want v=1 s1=abcd", out_valid, source1); end
    rst = 1'b1;
    set_wb(1'b1, 3'd7, 16'h5555);
    step();
    rst = 1'b0;
    idle();
    n_checks++; if (out_valid !== 1'b0 || alith !== 3'd0 || source1 !== 16'h0 || source2 !== 16'h0 || out_rd !== 3'd0)
      begin n_fail++; $display("FAIL rst_mid_outputs got v=%0b op=%b s1=%h s2=%h rd=%0d want all 0", out_valid, alith, source1, source2, out_rd); end
    issue(3'b000, 3'd0, 3'd5, 3'd7, 1'b0, 16'h0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %0b want 1", in_ready); end
    step();
    idle();
    n_checks++; if (out_valid !== 1'b1 || source1 !== 16'h0 || source2 !== 16'h0)
      begin n_fail++; $display("FAIL rst_mid_regs got v=%0b s1=%h s2=%h want v=1 0000 0000", out_valid, source1, source2); end
  endtask

  initial begin
    test_reset();
    test_basic_sub();
    test_imm_bypass();
    test_backpressure();
    test_back_to_back();
    test_waw();
    test_r0();
    test_reset_mid();
    out_ready = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Operand-fetch stage directly upstream of the 16-bit ALU. Holds an 8×16 register file. Accepts one decoded instruction per cycle and reads its source registers, with write-back bypass and an optional immediate. Registers `alith`/`source1`/`source2` into a valid/ready output stage feeding the ALU. A per-register busy scoreboard stalls instructions whose operands or destination still await write-back.

## Interface
- `WIDTH`, 16, data width of registers, immediates and operands
- `REGS`, 8, number of architectural registers; index width is clog2(REGS) = 3

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_alith`  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR; 1xx passed through unchanged
- `in_rd`  in  3  destination register
- `in_rs1`  in  3  first source register
- `in_rs2`  in  3  second source register, ignored when `in_use_imm`=1
- `in_use_imm`  in  1  source2 taken from `in_imm`
- `in_imm`  in  WIDTH  immediate operand
- `out_valid`  out  1  operands valid for ALU
- `out_ready`  in  1  ALU side consumes operands
- `alith`  out  3  registered op code to ALU
- `source1`  out  WIDTH  registered first operand
- `source2`  out  WIDTH  registered second operand
- `out_rd`  out  3  registered destination, travels with result to write-back
- `wb_en`  in  1  write-back strobe
- `wb_rd`  in  3  write-back register
- `wb_data`  in  WIDTH  write-back value (ALU result)

## Operation
- r0 always reads 0. Writes to r0 are discarded, and r0 is never marked busy.
- Read value of source rs:
  - 0 if rs=0
  - else `wb_data` if `wb_en` && `wb_rd`==rs (bypass)
  - else the register file content
- source2 = `in_imm` when `in_use_imm`=1, else the read value of rs2.
- Scoreboard: one busy bit per register.
  - Set on accept when `in_rd`≠0.
  - Cleared when `wb_en` and `wb_rd` matches.
  - Set and clear on the same register in one cycle: set wins.
- Hazard when any of these holds for a busy register r, unless `wb_en` && `wb_rd`==r this cycle:
  - rs1 = r
  - rs2 = r and `in_use_imm`=0
  - rd = r
- `in_ready` = (!`out_valid` || `out_ready`) && !hazard. This is combinational on the `in_*` fields and `wb_*` inputs.
- Accept: `in_valid` && `in_ready`. On accept, the output register loads alith, source1, source2 and rd, and `out_valid` is set to 1.
- No accept and `out_ready`=1: `out_valid` clears; other outputs hold their values.
- `out_valid`=1 and `out_ready`=0: all outputs hold stable.
- Register file write: at the clock edge when `wb_en`=1 and `wb_rd`≠0.
- Widths: no arithmetic is performed here; all fields pass through at full width. `alith` values 1xx are not altered or checked.

## Timing
- Reset values:
  - `out_valid`=0, `alith`=0, `source1`=0, `source2`=0, `out_rd`=0
  - all registers 0, all busy bits 0
- After reset, `in_ready`=1 for any instruction.
- Reset mid-operation:
  - a pending output is dropped
  - the scoreboard clears, so outstanding write-backs must be squashed by the downstream stage
  - the `wb_en` input in the reset cycle is ignored
- Latency: instruction accepted at edge N → operands on outputs with `out_valid`=1 after edge N. Operands reflect register/bypass state sampled in the accept cycle.
- Throughput: 1 instruction/cycle when there are no hazards and `out_ready`=1.
- Write-back at edge N is visible to an instruction accepted in cycle N through the bypass path.

## Test plan
- Reset, then write-back r1=5, r2=2; issue SUB rd=3, rs1=1, rs2=2 → next cycle `out_valid`=1, `alith`=001, `source1`=5, `source2`=2, `out_rd`=3.
- Issue ADD rd=1, rs1=0, imm=0x1234 with `in_use_imm`=1 → `source1`=0, `source2`=0x1234. A following instruction reading r1 sees `in_ready`=0 until `wb_en` with `wb_rd`=1, `wb_data`=0x1234. In that write-back cycle `in_ready`=1 and `source1`=0x1234 via bypass.
- Hold `out_ready`=0 with `out_valid`=1 for 3 cycles → `in_ready`=0 and `source1`/`source2`/`alith` stay unchanged. Release → next queued instruction appears one cycle later.
- WAW: issue rd=4, then another instruction with rd=4 → second is stalled until write-back of r4. Simultaneous clear and re-set leaves r4 busy.
- Write-back `wb_rd`=0, `wb_data`=0xFFFF, then read r0 → `source1`=0, and no busy bit is set for r0.
- Assert `rst` while `out_valid`=1 and r5 is busy → next cycle all outputs 0, `in_ready`=1 for an instruction reading r5, and r5 reads 0.
